// File: rtl/rx_frame_arbiter.sv
// =============================================================================
// Module : rx_frame_arbiter
// Desc   : Round-robin frame arbiter from four RX FIFOs to one tagged byte
//          stream. Define RX_ARB_TIMEOUT_EN for the per-frame stall timeout.
// Rev    : 1.0  initial release
// =============================================================================
`default_nettype none

module rx_frame_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TCNT_W         = 13
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [3:0]  i_fifo_empty,
  input  logic [31:0] i_fifo_dout,
  input  logic [3:0]  i_fifo_del,
  output logic [3:0]  i_fifo_rden,
  input  logic [3:0]  mask_port,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        o_ready,
  output logic        o_sof,
  output logic        o_eof,
  output logic [1:0]  o_port,
  output logic        o_busy,
  output logic        o_abort
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic        inflight_q, inflight_d;
  logic        first_q, first_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [1:0]  port_q, port_d;
  logic [3:0]  w_rden;
  logic [3:0]  w_req;
  logic        w_found;
  logic [1:0]  w_pick;
  logic [1:0]  w_idx;
  logic        w_out_free;
`ifdef RX_ARB_TIMEOUT_EN
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              abort_q, abort_d;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      grant_q    <= 2'd0;
      inflight_q <= 1'b0;
      first_q    <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      port_q     <= 2'd0;
`ifdef RX_ARB_TIMEOUT_EN
      tcnt_q     <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      inflight_q <= inflight_d;
      first_q    <= first_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      port_q     <= port_d;
`ifdef RX_ARB_TIMEOUT_EN
      tcnt_q     <= tcnt_d;
      abort_q    <= abort_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    inflight_d = inflight_q;
    first_d    = first_q;
    data_d     = data_q;
    valid_d    = valid_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    port_d     = port_q;
    w_rden     = 4'b0000;
`ifdef RX_ARB_TIMEOUT_EN
    tcnt_d     = tcnt_q;
    abort_d    = 1'b0;
`endif
    w_req      = ~i_fifo_empty & ~mask_port;
    w_found    = 1'b0;
    w_pick     = rr_ptr_q;
    w_idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = rr_ptr_q + 2'(k);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    // A read may only be issued when its byte is sure to land in an empty register.
    w_out_free = ~valid_q | o_ready;
    if (valid_q && o_ready) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d = w_pick;
          first_d = 1'b1;
          state_d = ST_STREAM;
`ifdef RX_ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
          if (w_out_free) port_d = w_pick;
        end
      end
      ST_STREAM: begin
        if (inflight_q) begin
          inflight_d = 1'b0;
          data_d     = i_fifo_dout[{grant_q, 3'b000} +: 8];
          valid_d    = 1'b1;
          sof_d      = first_q;
          eof_d      = i_fifo_del[grant_q];
          port_d     = grant_q;
          first_d    = 1'b0;
`ifdef RX_ARB_TIMEOUT_EN
          tcnt_d     = '0;
`endif
          if (i_fifo_del[grant_q]) begin
            rr_ptr_d = grant_q + 2'd1;
            state_d  = ST_IDLE;
          end
        end
`ifdef RX_ARB_TIMEOUT_EN
        else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_d  = 1'b1;
          rr_ptr_d = grant_q + 2'd1;
          state_d  = ST_IDLE;
          tcnt_d   = '0;
        end
`endif
        else begin
`ifdef RX_ARB_TIMEOUT_EN
          tcnt_d = tcnt_q + TCNT_W'(1);
`endif
          if (!i_fifo_empty[grant_q] && w_out_free) begin
            w_rden[grant_q] = 1'b1;
            inflight_d      = 1'b1;
          end
        end
      end
    endcase
  end

  assign i_fifo_rden = w_rden;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eof       = eof_q;
  assign o_port      = port_q;
  assign o_busy      = (state_q == ST_STREAM);
`ifdef RX_ARB_TIMEOUT_EN
  assign o_abort     = abort_q;
`else
  // Constant 0 for every legal configuration; no stall counter exists here.
  assign o_abort     = (TCNT_W == 0) && (TIMEOUT_CYCLES == 0);
`endif

endmodule

`default_nettype wire
